// File: rtl/prog_mem.sv
// In-system-writable program memory for the TD4 core: combinational fetch port plus a
// valid/ready byte-stream loader. Define PROG_MEM_CHECKSUM_EN to add a trailing checksum beat.
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              cpu_hold
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef PROG_MEM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic              beat;
  logic              load_beat;
  logic              start_accept;

  assign beat         = ld_valid & ld_ready;
  assign load_beat    = beat && (state == LOAD);
  assign start_accept = ld_start && (state == IDLE);

  // Fetch stays live during a load; the CPU is stalled by cpu_hold instead.
  assign data = mem[address];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (beat && (wp == LAST_ADDR)) begin
`ifdef PROG_MEM_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef PROG_MEM_CHECKSUM_EN
      CHECK: begin
        if (beat) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    cpu_hold = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
      end
`ifdef PROG_MEM_CHECKSUM_EN
      CHECK: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
      end
`endif
      DONE: begin
        ld_done  = 1'b1;
        cpu_hold = 1'b1;
      end
      default: begin
        ld_ready = 1'b0;
      end
    endcase
  end

  // wp cannot wrap into a second pass: LOAD is left on the beat written at DEPTH-1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wp <= '0;
    end else if (start_accept) begin
      wp <= '0;
    end else if (load_beat) begin
      wp <= wp + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_beat) begin
      mem[wp] <= ld_data;
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              err_q;

  // Running sum wraps modulo 2**DATA_W; the image is kept even when the check fails.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (start_accept) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (load_beat) begin
      sum <= sum + ld_data;
    end else if (beat && (state == CHECK)) begin
      err_q <= (ld_data != sum);
    end
  end

  assign ld_err = err_q;
`else
  assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: a default 16x8 instance and a 32x12 instance,
// with expected memory contents queued as beats are driven and popped on read-back.
module tb_prog_mem;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic [7:0]  data;
  logic        ld_start, ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready, ld_done, ld_err, cpu_hold;

  logic [4:0]  address2;
  logic [11:0] data2;
  logic        ld_start2, ld_valid2;
  logic [11:0] ld_data2;
  logic        ld_ready2, ld_done2, ld_err2, cpu_hold2;

  int total = 0;
  int bad = 0;
  logic [31:0] expq [$];
  logic [7:0]  model [16];
  logic [7:0]  img [16];
  logic [7:0]  csum;
  logic [11:0] sum2;

  always #5 clock = ~clock;

  prog_mem dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data(data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .cpu_hold(cpu_hold)
  );

  prog_mem #(.ADDR_W(5), .DATA_W(12)) dut2 (
    .clock(clock), .reset_n(reset_n), .address(address2), .data(data2),
    .ld_start(ld_start2), .ld_valid(ld_valid2), .ld_data(ld_data2),
    .ld_ready(ld_ready2), .ld_done(ld_done2), .ld_err(ld_err2), .cpu_hold(cpu_hold2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic readBack;
    logic [31:0] exp;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      if (expq.size() == 0) begin
        checkOutput("queue_empty", 32'd1, 32'd0);
      end else begin
        exp = expq.pop_front();
        checkOutput("readback", {24'd0, data}, exp);
      end
    end
  endtask

  // One full image load from img[]; optional valid gap and a spurious mid-load ld_start.
  task automatic applyStimulus(input int gapAt, input int gapLen, input int restartAt,
                               input logic [7:0] sumBeat, input logic expErr);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    checkOutput("hold_rise", {31'd0, cpu_hold}, 32'd1);
    checkOutput("ready_load", {31'd0, ld_ready}, 32'd1);
    checkOutput("err_cleared", {31'd0, ld_err}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_start = (i == restartAt);
      checkOutput("hold_load", {31'd0, cpu_hold}, 32'd1);
      checkOutput("done_early", {31'd0, ld_done}, 32'd0);
      tick();
      model[i] = img[i];
      ld_start = 1'b0;
      if (i == gapAt) begin
        ld_valid = 1'b0;
        ld_data  = 8'h5A;
        address  = 4'(i + 1);
        for (int g = 0; g < gapLen; g++) begin
          tick();
          checkOutput("gap_nowrite", {24'd0, data}, {24'd0, model[i+1]});
          checkOutput("gap_ready", {31'd0, ld_ready}, 32'd1);
          checkOutput("gap_hold", {31'd0, cpu_hold}, 32'd1);
        end
      end
    end
`ifdef PROG_MEM_CHECKSUM_EN
    ld_valid = 1'b1;
    ld_data  = sumBeat;
    checkOutput("done_before_csum", {31'd0, ld_done}, 32'd0);
    tick();
`endif
    ld_valid = 1'b0;
    checkOutput("done_pulse", {31'd0, ld_done}, 32'd1);
    checkOutput("hold_done", {31'd0, cpu_hold}, 32'd1);
    checkOutput("ready_done", {31'd0, ld_ready}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
    checkOutput("err_done", {31'd0, ld_err}, {31'd0, expErr});
`else
    checkOutput("err_done", {31'd0, ld_err}, 32'd0);
`endif
    tick();
    checkOutput("done_fall", {31'd0, ld_done}, 32'd0);
    checkOutput("hold_fall", {31'd0, cpu_hold}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
    checkOutput("err_sticky", {31'd0, ld_err}, {31'd0, expErr});
`else
    checkOutput("err_sticky", {31'd0, ld_err}, 32'd0);
`endif
    for (int a = 0; a < 16; a++) begin
      expq.push_back({24'd0, model[a]});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    address = '0;   ld_start = 1'b0;  ld_valid = 1'b0;  ld_data = '0;
    address2 = '0;  ld_start2 = 1'b0; ld_valid2 = 1'b0; ld_data2 = '0;
    for (int a = 0; a < 16; a++) model[a] = 8'h00;

    tick();
    tick();
    reset_n = 1'b1;
    checkOutput("rst_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("rst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("rst_done", {31'd0, ld_done}, 32'd0);
    checkOutput("rst_err", {31'd0, ld_err}, 32'd0);
    for (int a = 0; a < 16; a++) expq.push_back(32'd0);
    readBack();

    img = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
            8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
    csum = 8'h00;
    for (int i = 0; i < 16; i++) csum = csum + img[i];
    applyStimulus(-1, 0, -1, csum, 1'b0);
    address = 4'd0;
    #1;
    checkOutput("img_addr0", {24'd0, data}, 32'hB7);
    address = 4'd15;
    #1;
    checkOutput("img_addr15", {24'd0, data}, 32'hFF);
    readBack();

    applyStimulus(7, 5, 5, csum, 1'b0);
    readBack();

    for (int i = 0; i < 16; i++) img[i] = 8'h10;
    applyStimulus(-1, 0, -1, 8'h00, 1'b0);
    readBack();
    applyStimulus(-1, 0, -1, 8'h01, 1'b1);
    readBack();

    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    checkOutput("err_clear_on_start", {31'd0, ld_err}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(8'h20 + i);
      tick();
    end
    ld_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n  = 1'b1;
    checkOutput("midrst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("midrst_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("midrst_done", {31'd0, ld_done}, 32'd0);
    checkOutput("midrst_err", {31'd0, ld_err}, 32'd0);
    address = 4'd3;
    #1;
    checkOutput("midrst_addr3", {24'd0, data}, 32'd0);
    tick();
    checkOutput("midrst_idle", {31'd0, ld_ready}, 32'd0);
    for (int a = 0; a < 16; a++) expq.push_back(32'd0);
    readBack();

    ld_start2 = 1'b1;
    tick();
    ld_start2 = 1'b0;
    checkOutput("d2_hold_rise", {31'd0, cpu_hold2}, 32'd1);
    sum2 = '0;
    for (int i = 0; i < 32; i++) begin
      ld_valid2 = 1'b1;
      ld_data2  = 12'(i * 3);
      sum2      = sum2 + 12'(i * 3);
      expq.push_back(32'(i * 3));
      checkOutput("d2_done_early", {31'd0, ld_done2}, 32'd0);
      tick();
    end
`ifdef PROG_MEM_CHECKSUM_EN
    ld_data2 = sum2;
    checkOutput("d2_done_before_csum", {31'd0, ld_done2}, 32'd0);
    tick();
`endif
    ld_valid2 = 1'b0;
    checkOutput("d2_done_pulse", {31'd0, ld_done2}, 32'd1);
    checkOutput("d2_err", {31'd0, ld_err2}, 32'd0);
    tick();
    checkOutput("d2_done_fall", {31'd0, ld_done2}, 32'd0);
    checkOutput("d2_hold_fall", {31'd0, cpu_hold2}, 32'd0);
    address2 = 5'd31;
    #1;
    checkOutput("d2_addr31", {20'd0, data2}, 32'd93);
    for (int a = 0; a < 32; a++) begin
      address2 = 5'(a);
      #1;
      if (expq.size() == 0) begin
        checkOutput("d2_queue_empty", 32'd1, 32'd0);
      end else begin
        checkOutput("d2_readback", {20'd0, data2}, expq.pop_front());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, in-system-writable program memory for the TD4 CPU core. It replaces the fixed instruction ROM. The instruction fetch path is a combinational read addressed by the PC. A byte-stream loader, with a valid/ready handshake, rewrites the whole image while holding the CPU off via `cpu_hold`. An optional trailing checksum beat validates the loaded image.

## Interface
- `ADDR_W`, default 4: address width; memory depth `DEPTH = 2**ADDR_W`.
- `DATA_W`, default 8: instruction word width.

- `clock`  in  1: the single clock. All state changes on its rising edge.
- `reset_n`  in  1: synchronous reset, active-low.
- `address`  in  ADDR_W: fetch address from the PC.
- `data`  out  DATA_W: instruction word at `address`.
- `ld_start`  in  1: request a full image load. Honoured only in IDLE.
- `ld_valid`  in  1: `ld_data` carries a beat.
- `ld_data`  in  DATA_W: load beat, either an image word or the checksum.
- `ld_ready`  out  1: loader accepts a beat this cycle.
- `ld_done`  out  1: one-cycle pulse when the load completes.
- `ld_err`  out  1: checksum mismatch on the last load. Sticky until the next accepted `ld_start`.
- `cpu_hold`  out  1: CPU must not advance its PC or registers.

## Operation
- Storage: DEPTH x DATA_W register array.
  - Synchronous reset clears every word to 0. Opcode 0x00 is `ADD A,0`, a harmless NOP-like instruction.
- Read path: `data = mem[address]`, purely combinational.
  - A write at edge N is visible on `data` after edge N.
  - Reads stay live during loading. The CPU is stalled by `cpu_hold`, not by gating `data`.
- FSM states: IDLE, LOAD, CHECK (only with the macro), DONE.
- IDLE:
  - `ld_ready`=0, `cpu_hold`=0.
  - `ld_start`=1 moves to LOAD, clears the write pointer `wp` to 0, and clears `ld_err`.
- LOAD:
  - `ld_ready`=1, `cpu_hold`=1.
  - Each beat (`ld_valid & ld_ready`) writes `mem[wp]=ld_data` and increments `wp`.
  - The beat written at `wp==DEPTH-1` moves to CHECK if the macro is defined, otherwise to DONE.
  - `ld_valid`=0 stalls the loader indefinitely with no timeout.
- CHECK:
  - `ld_ready`=1, `cpu_hold`=1.
  - One accepted beat is compared with the running sum of all DEPTH words, modulo 2^DATA_W (carries discarded).
  - On mismatch, `ld_err` is set to 1. Either way the FSM moves to DONE.
  - The image is kept even on mismatch.
- DONE:
  - `ld_done`=1 and `cpu_hold`=1 for exactly one cycle, then IDLE.
- `ld_start` outside IDLE is ignored and never restarts a load.
- Reset mid-load: the FSM returns to IDLE, all words go to 0, and `ld_err`, `wp` and all outputs are cleared. The partial image is discarded.
- `wp` is ADDR_W bits wide. Wrap from DEPTH-1 to 0 never stores an extra word, because the state exits LOAD on that beat.

## Timing
- Reset values: `ld_ready`=0, `ld_done`=0, `ld_err`=0, `cpu_hold`=0, `data`=0.
- `cpu_hold` rises the cycle after `ld_start` is sampled in IDLE. It falls the cycle after DONE.
- Minimum load duration from the `ld_start` edge to IDLE:
  - DEPTH+2 cycles without the macro.
  - DEPTH+3 cycles with the macro.
- `ld_done` asserts the cycle after the final accepted beat.
- `ld_err` is valid from the DONE cycle onward.
- Fetch latency is 0 cycles (combinational).

## Configuration
- `PROG_MEM_CHECKSUM_EN` defined:
  - The CHECK state and the running-sum register exist.
  - Each load needs DEPTH+1 beats.
  - `ld_err` reports a mismatch.
- `PROG_MEM_CHECKSUM_EN` undefined:
  - No CHECK state and no sum register.
  - Each load takes exactly DEPTH beats.
  - `ld_err` is tied to 0.

## Test plan
- Reset with `reset_n`=0 for 2 cycles, then sweep `address` 0..15 -> `data`=0x00 everywhere, `ld_ready`=0, `cpu_hold`=0.
- Pulse `ld_start`, then stream 16 beats back-to-back: 0xB7, 0x01, 0xE1, 0x01, 0xE3, 0xB6, 0x01, 0xE6, 0x01, 0xE8, 0xB0, 0xB4, 0x01, 0xEA, 0xB8, 0xFF. Expected response:
  - `cpu_hold` is high throughout.
  - `ld_done` pulses one cycle after beat 15.
  - A read of `address`=0 gives 0xB7, and 15 gives 0xFF.
- Same load with `ld_valid` dropped for 5 cycles after beat 7 -> no write during the gap and the identical final image. Send a second `ld_start` mid-load -> it is ignored and the word count is still 16.
- Macro on, 16 beats of 0x10 followed by checksum 0x00 -> `ld_err`=0. Repeat with checksum 0x01 -> `ld_err`=1. The next `ld_start` clears it.
- Drive `reset_n`=0 after 9 beats -> next cycle `cpu_hold`=0 and FSM in IDLE. A read of `address`=3 gives 0x00.
- `ADDR_W`=5, `DATA_W`=12: load 32 beats of `i*3` -> `mem[31]`=93, and `ld_done` pulses after exactly 32 beats (33 with the macro).
